// File: rtl/usb_utmi_phy_responder_pkg.sv
// Shared constants for the UTMI PHY responder: FSM state codes, linestate encodings and USB PIDs.
// PIDs are not used by the PHY logic itself; benches use them to build packets.
package usb_phy_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BUSRST  = 3'd1;
    localparam logic [2:0] ST_RX_SYNC = 3'd2;
    localparam logic [2:0] ST_RX_DATA = 3'd3;
    localparam logic [2:0] ST_TX_CAP  = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10
    } linestate_e;

    localparam logic [7:0] PID_TOKEN_IN = 8'h69;
    localparam logic [7:0] PID_OUT      = 8'hE1;
    localparam logic [7:0] PID_SETUP    = 8'h2D;
    localparam logic [7:0] PID_DATA0    = 8'hC3;
    localparam logic [7:0] PID_DATA1    = 8'h4B;
    localparam logic [7:0] PID_ACK      = 8'hD2;
    localparam logic [7:0] PID_NAK      = 8'h5A;

endpackage

// File: rtl/usb_utmi_phy_responder_if.sv
// UTMI link between PHY (phy modport drives rx signalling, txready, linestate) and device core (dev).
// Device holds txvalid/data_out until the PHY raises txready.
interface usb_utmi_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] data_in;
    logic              rxvalid;
    logic              rxactive;
    logic              rxerror;
    logic [1:0]        linestate;
    logic              txready;
    logic [DATA_W-1:0] data_out;
    logic              txvalid;

    modport phy (
        output data_in, rxvalid, rxactive, rxerror, linestate, txready,
        input  data_out, txvalid
    );

    modport dev (
        input  data_in, rxvalid, rxactive, rxerror, linestate, txready,
        output data_out, txvalid
    );
endinterface

// File: rtl/usb_utmi_phy_responder_skid.sv
// One-entry valid/ready register carrying a byte plus last flag; 1 cycle latency.
// Accepts a new entry when empty or when the held one drains the same cycle.
module usb_phy_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld_i,
    input  logic [DATA_W-1:0] in_dat_i,
    input  logic              in_last_i,
    output logic              in_rdy_o,
    output logic              out_vld_o,
    output logic [DATA_W-1:0] out_dat_o,
    output logic              out_last_o,
    input  logic              out_rdy_i
);
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    assign in_rdy_o   = !vld_q || out_rdy_i;
    assign out_vld_o  = vld_q;
    assign out_dat_o  = dat_q;
    assign out_last_o = last_q;

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        dat_d  = dat_q;
        if (in_vld_i && in_rdy_o) begin
            vld_d  = 1'b1;
            last_d = in_last_i;
            dat_d  = in_dat_i;
        end else if (out_rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            dat_q  <= dat_d;
        end
    end
endmodule

// File: rtl/usb_utmi_phy_responder.sv
// PHY end of a UTMI link: host bytes -> rx signalling (rxvalid 1 cycle after accept), device tx -> pkt_out (<=2 cycles after txvalid falls).
// pkt_out backpressure stalls txready, never drops bytes. Optional USB_PHY_RXERR_INJ_EN adds inject_err.
module usb_utmi_phy_responder
    import usb_phy_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int SYNC_CYCLES  = 2,
    parameter int IPG_CYCLES   = 4,
    parameter int RESET_CYCLES = 100,
    parameter int TXREADY_GAP  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pkt_in_data,
    input  logic              pkt_in_valid,
    input  logic              pkt_in_last,
    output logic              pkt_in_ready,
    output logic [DATA_W-1:0] pkt_out_data,
    output logic              pkt_out_valid,
    output logic              pkt_out_last,
    input  logic              pkt_out_ready,
    input  logic              bus_reset_req,
`ifdef USB_PHY_RXERR_INJ_EN
    input  logic              inject_err,
`endif
    usb_utmi_if.phy           usb_utmi,
    output logic              busy
);
    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        pace_q, pace_d;
    logic              rst_pend_q, rst_pend_d;
    logic              rx_done_q, rx_done_d, rx_drop_q, rx_drop_d;
    logic              rxvalid_q, rxvalid_d, rxerror_q, rxerror_d;
    logic [DATA_W-1:0] rx_dat_q, rx_dat_d, hold_dat_q, hold_dat_d;
    logic              hold_full_q, hold_full_d;
    logic              sync_last, rx_acc, tx_acc, tx_flush, err_in;
    logic              skid_in_vld, skid_in_rdy;

`ifdef USB_PHY_RXERR_INJ_EN
    assign err_in = inject_err;
`else
    assign err_in = 1'b0;
`endif

    // First byte is taken in the last SYNC cycle so rxvalid follows SYNC without a hole.
    assign sync_last    = (cnt_q == 16'(SYNC_CYCLES - 1));
    assign pkt_in_ready = (state_q == ST_RX_SYNC && sync_last) || (state_q == ST_RX_DATA && !rx_done_q);
    assign rx_acc       = pkt_in_valid && pkt_in_ready;

    assign usb_utmi.txready   = (state_q == ST_TX_CAP) && usb_utmi.txvalid
                              && (!hold_full_q || skid_in_rdy) && (pace_q == 8'd0);
    assign tx_acc             = usb_utmi.txvalid && usb_utmi.txready;
    assign tx_flush           = (state_q == ST_TX_CAP) && !usb_utmi.txvalid && hold_full_q;
    assign skid_in_vld        = (tx_acc && hold_full_q) || tx_flush;

    assign usb_utmi.data_in   = rx_dat_q;
    assign usb_utmi.rxvalid   = rxvalid_q;
    assign usb_utmi.rxerror   = rxerror_q;
    assign usb_utmi.rxactive  = (state_q == ST_RX_SYNC) || (state_q == ST_RX_DATA);
    assign usb_utmi.linestate = (state_q == ST_BUSRST) ? LS_SE0 : LS_J;
    assign busy               = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        pace_d      = (pace_q != 8'd0) ? pace_q - 8'd1 : pace_q;
        rst_pend_d  = rst_pend_q || (bus_reset_req && state_q != ST_IDLE);
        rxvalid_d   = rx_acc && !rx_drop_q && !err_in;
        rxerror_d   = rx_acc && !rx_drop_q && err_in;
        rx_dat_d    = rx_acc ? pkt_in_data : rx_dat_q;
        rx_drop_d   = rx_drop_q || (rx_acc && err_in);
        rx_done_d   = rx_done_q || (rx_acc && pkt_in_last);
        hold_dat_d  = hold_dat_q;
        hold_full_d = hold_full_q;
        if (tx_acc) begin
            hold_dat_d  = usb_utmi.data_out;
            hold_full_d = 1'b1;
            pace_d      = 8'(TXREADY_GAP);
        end else if (tx_flush && skid_in_rdy) begin
            hold_full_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus_reset_req || rst_pend_q) begin
                    state_d    = ST_BUSRST;
                    rst_pend_d = 1'b0;
                end else if (usb_utmi.txvalid) begin
                    state_d = ST_TX_CAP;
                end else if (pkt_in_valid) begin
                    state_d = ST_RX_SYNC;
                end
            end
            ST_BUSRST: if (cnt_q == 16'(RESET_CYCLES - 1)) begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_RX_SYNC: if (sync_last) begin
                state_d = ST_RX_DATA;
                cnt_d   = '0;
            end
            ST_RX_DATA: if (rx_done_q) begin
                state_d   = ST_GAP;
                cnt_d     = '0;
                rx_done_d = 1'b0;
                rx_drop_d = 1'b0;
            end
            ST_TX_CAP: if (!usb_utmi.txvalid && (!hold_full_q || skid_in_rdy)) begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: if (cnt_q == 16'(IPG_CYCLES - 1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pace_q      <= '0;
            rst_pend_q  <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_drop_q   <= 1'b0;
            rxvalid_q   <= 1'b0;
            rxerror_q   <= 1'b0;
            rx_dat_q    <= '0;
            hold_dat_q  <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pace_q      <= pace_d;
            rst_pend_q  <= rst_pend_d;
            rx_done_q   <= rx_done_d;
            rx_drop_q   <= rx_drop_d;
            rxvalid_q   <= rxvalid_d;
            rxerror_q   <= rxerror_d;
            rx_dat_q    <= rx_dat_d;
            hold_dat_q  <= hold_dat_d;
            hold_full_q <= hold_full_d;
        end
    end

    usb_phy_skid #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_vld_i   (skid_in_vld),
        .in_dat_i   (hold_dat_q),
        .in_last_i  (tx_flush),
        .in_rdy_o   (skid_in_rdy),
        .out_vld_o  (pkt_out_valid),
        .out_dat_o  (pkt_out_data),
        .out_last_o (pkt_out_last),
        .out_rdy_i  (pkt_out_ready)
    );
endmodule

// File: tb/tb_usb_utmi_phy_responder.sv
// Directed bench: host/device/downstream models driven per cycle, traces recorded, then compared to hand-derived timelines.
module tb_usb_utmi_phy_responder;
    import usb_phy_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] pkt_in_data, pkt_out_data;
    logic       pkt_in_valid, pkt_in_last, pkt_in_ready;
    logic       pkt_out_valid, pkt_out_last, pkt_out_ready;
    logic       bus_reset_req, busy;
`ifdef USB_PHY_RXERR_INJ_EN
    logic       inject_err;
`endif

    usb_utmi_if #(.DATA_W(8)) utmi ();

    usb_utmi_phy_responder dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_in_data   (pkt_in_data),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_last   (pkt_in_last),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_out_data  (pkt_out_data),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_last  (pkt_out_last),
        .pkt_out_ready (pkt_out_ready),
        .bus_reset_req (bus_reset_req),
`ifdef USB_PHY_RXERR_INJ_EN
        .inject_err    (inject_err),
`endif
        .usb_utmi      (utmi),
        .busy          (busy)
    );

    int checks, errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus models
    logic [7:0] h_dat [16];
    logic       h_inj [16];
    int         h_len, h_idx;
    logic [7:0] d_dat [8];
    int         d_len, d_idx, d_start;
    int         bp_lo, bp_hi, br_cyc;
    // recorded traces
    logic       r_act [128], r_vld [128], r_err [128], r_txr [128], r_busy [128], r_pir [128];
    logic [7:0] r_dat [128];
    logic [1:0] r_ls  [128];
    logic [7:0] o_dat [8];
    logic       o_last [8];
    int         o_cyc [8];
    int         o_n;
    logic       prev_hold, prev_last;
    logic [7:0] prev_dat;

    task automatic clr();
        h_len = 0; h_idx = 0; d_len = 0; d_idx = 0; d_start = 0;
        bp_lo = 0; bp_hi = 0; br_cyc = -1; o_n = 0; prev_hold = 1'b0;
        for (int i = 0; i < 16; i++) begin h_dat[i] = 8'h00; h_inj[i] = 1'b0; end
        for (int i = 0; i < 8; i++) begin d_dat[i] = 8'h00; o_dat[i] = 8'h00; o_last[i] = 1'b0; o_cyc[i] = -1; end
    endtask

    task automatic idle_inputs();
        pkt_in_data = 8'h00; pkt_in_valid = 1'b0; pkt_in_last = 1'b0;
        pkt_out_ready = 1'b1; bus_reset_req = 1'b0;
        utmi.txvalid = 1'b0; utmi.data_out = 8'h00;
`ifdef USB_PHY_RXERR_INJ_EN
        inject_err = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        pkt_out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_linestate", utmi.linestate, LS_J);
        chk("rst_rxactive", utmi.rxactive, 0);
        chk("rst_rxvalid", utmi.rxvalid, 0);
        chk("rst_rxerror", utmi.rxerror, 0);
        chk("rst_txready", utmi.txready, 0);
        chk("rst_pkt_in_ready", pkt_in_ready, 0);
        chk("rst_pkt_out_valid", {pkt_out_valid, pkt_out_last}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        pkt_out_ready = 1'b1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            pkt_in_valid  = (h_idx < h_len);
            pkt_in_data   = h_dat[h_idx];
            pkt_in_last   = (h_idx == h_len - 1);
`ifdef USB_PHY_RXERR_INJ_EN
            inject_err    = h_inj[h_idx] && pkt_in_valid;
`endif
            utmi.txvalid  = (c >= d_start) && (d_idx < d_len);
            utmi.data_out = d_dat[d_idx];
            pkt_out_ready = !(c >= bp_lo && c < bp_hi);
            bus_reset_req = (c == br_cyc);
            #1;
            r_act[c] = utmi.rxactive; r_vld[c] = utmi.rxvalid; r_err[c] = utmi.rxerror;
            r_dat[c] = utmi.data_in;  r_ls[c]  = utmi.linestate; r_txr[c] = utmi.txready;
            r_busy[c] = busy;         r_pir[c] = pkt_in_ready;
            if (prev_hold) begin
                chk("out_hold_valid", pkt_out_valid, 1);
                chk("out_hold_stable", {pkt_out_last, pkt_out_data}, {prev_last, prev_dat});
            end
            prev_hold = pkt_out_valid && !pkt_out_ready;
            prev_dat  = pkt_out_data;
            prev_last = pkt_out_last;
            if (pkt_out_valid && pkt_out_ready && o_n < 8) begin
                o_dat[o_n] = pkt_out_data; o_last[o_n] = pkt_out_last; o_cyc[o_n] = c; o_n++;
            end
            if (pkt_in_valid && pkt_in_ready) h_idx++;
            if (utmi.txvalid && utmi.txready) d_idx++;
        end
    endtask

    function automatic int count_txr(input int lo, input int hi);
        int s = 0;
        for (int c = lo; c < hi; c++) s += int'(r_txr[c]);
        return s;
    endfunction

    function automatic int count_vld(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) s += int'(r_vld[c]);
        return s;
    endfunction

    logic [7:0] exp3 [3];
    int cnt;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        idle_inputs();

        // IN token 69,00,10
        do_reset(); clr();
        h_len = 3; h_dat[0] = PID_TOKEN_IN; h_dat[1] = 8'h00; h_dat[2] = 8'h10;
        run(12);
        chk("in_idle_act", r_act[0], 0);
        chk("in_sync", {r_act[1], r_vld[1], r_act[2], r_vld[2]}, 4'b1010);
        chk("in_ready_sync", r_pir[2], 1);
        exp3[0] = 8'h69; exp3[1] = 8'h00; exp3[2] = 8'h10;
        for (int i = 0; i < 3; i++) chk($sformatf("in_byte%0d", i), {r_act[3+i], r_vld[3+i], r_dat[3+i]}, {2'b11, exp3[i]});
        chk("in_act_fall", {r_act[6], r_vld[6]}, 0);
        chk("in_busy_gap", r_busy[9], 1);
        chk("in_busy_idle", r_busy[10], 0);

        // Device DATA1 4B,AA,55 with downstream always ready
        do_reset(); clr();
        d_len = 3; d_dat[0] = PID_DATA1; d_dat[1] = 8'hAA; d_dat[2] = 8'h55;
        run(12);
        exp3[0] = PID_DATA1; exp3[1] = 8'hAA; exp3[2] = 8'h55;
        chk("tx_txready_cnt", count_txr(0, 12), 3);
        chk("tx_out_cnt", o_n, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("tx_out%0d", i), {o_last[i], o_dat[i]}, {(i == 2), exp3[i]});
        chk("tx_last_cycle", o_cyc[2], 5);
        chk("tx_busy_idle", r_busy[9], 0);

        // Same tx, downstream stalls cycles 3..7
        do_reset(); clr();
        d_len = 3; d_dat[0] = PID_DATA1; d_dat[1] = 8'hAA; d_dat[2] = 8'h55;
        bp_lo = 3; bp_hi = 8;
        run(16);
        chk("bp_txready_stall", count_txr(3, 8), 0);
        chk("bp_txready_cnt", count_txr(0, 16), 3);
        chk("bp_txready_resume", r_txr[8], 1);
        chk("bp_out_cnt", o_n, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("bp_out%0d", i), {o_last[i], o_dat[i]}, {(i == 2), exp3[i]});
        chk("bp_first_cycle", o_cyc[0], 8);
        chk("bp_last_cycle", o_cyc[2], 10);

        // Collision: device ACK and host SETUP start together
        do_reset(); clr();
        d_len = 1; d_dat[0] = PID_ACK;
        h_len = 3; h_dat[0] = PID_SETUP; h_dat[1] = 8'h00; h_dat[2] = 8'h10;
        run(16);
        chk("col_out", {o_n[3:0], o_last[0], o_dat[0]}, {4'd1, 1'b1, PID_ACK});
        chk("col_out_cycle", o_cyc[0], 3);
        cnt = 0;
        for (int c = 0; c < 8; c++) cnt += int'(r_pir[c]) + int'(r_act[c]);
        chk("col_host_held", cnt, 0);
        chk("col_rx_start", r_act[8], 1);
        chk("col_rx_first", {r_vld[10], r_dat[10]}, {1'b1, PID_SETUP});
        chk("col_rx_cnt", count_vld(16), 3);

        // Bus reset requested while a host packet is in RX_DATA
        do_reset(); clr();
        h_len = 3; h_dat[0] = PID_TOKEN_IN; h_dat[1] = 8'h00; h_dat[2] = 8'h10;
        br_cyc = 4;
        run(116);
        chk("br_pkt_done", count_vld(116), 3);
        cnt = 0;
        for (int c = 0; c < 116; c++) cnt += int'(r_ls[c] == LS_SE0);
        chk("br_se0_len", cnt, 100);
        chk("br_se0_edges", {r_ls[10], r_ls[11], r_ls[110], r_ls[111]}, {LS_J, LS_SE0, LS_SE0, LS_J});

`ifdef USB_PHY_RXERR_INJ_EN
        // DATA0 of 8 bytes with error injected on the third byte
        do_reset(); clr();
        h_len = 8; h_dat[0] = PID_DATA0;
        for (int i = 1; i < 8; i++) h_dat[i] = 8'(i);
        h_inj[2] = 1'b1;
        run(16);
        chk("inj_err_cycle", {r_err[5], r_vld[5]}, 2'b10);
        cnt = 0;
        for (int c = 0; c < 16; c++) cnt += int'(r_err[c]);
        chk("inj_err_cnt", cnt, 1);
        chk("inj_vld_cnt", count_vld(16), 2);
        chk("inj_consumed", h_idx, 8);
        chk("inj_act_fall", {r_act[10], r_act[11]}, 2'b10);
        clr();
        h_len = 3; h_dat[0] = PID_TOKEN_IN; h_dat[1] = 8'h00; h_dat[2] = 8'h10;
        run(12);
        chk("inj_next_cnt", count_vld(12), 3);
        chk("inj_next_first", {r_vld[3], r_err[3], r_dat[3]}, {2'b10, PID_TOKEN_IN});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_utmi_phy_responder.md
Name: usb_utmi_phy_responder

Overview:
- PHY-side end of the UTMI link that the Microwatt USB device core drives.
- Turns host-packet byte streams into UTMI receive signalling (rxactive, rxvalid, data_in, linestate) toward the device.
- Captures the device's transmit bytes (txvalid/data_out) under txready pacing into an outbound byte stream.
- Synthesizable. Used both as an on-chip loopback/debug PHY and as the bench-side PHY for USB tests.

Parameters:
- DATA_W, 8, UTMI data width.
- SYNC_CYCLES, 2, cycles rxactive is high before the first rxvalid (models SYNC).
- IPG_CYCLES, 4, minimum idle cycles between any two packets, either direction.
- RESET_CYCLES, 100, cycles linestate is held at SE0 on a bus reset.
- TXREADY_GAP, 0, idle cycles forced between accepted device tx bytes (0 = back-to-back).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pkt_in_data  in  DATA_W  host-packet byte toward device
- pkt_in_valid  in  1  byte valid
- pkt_in_last  in  1  final byte of packet
- pkt_in_ready  out  1  byte accepted when valid&ready
- pkt_out_data  out  DATA_W  captured device-tx byte
- pkt_out_valid  out  1  output byte valid
- pkt_out_last  out  1  final byte of captured packet
- pkt_out_ready  in  1  downstream accepts
- bus_reset_req  in  1  one-cycle pulse; drive SE0 for RESET_CYCLES
- usb_utmi_data_in  out  DATA_W  rx data to device
- usb_utmi_rxvalid  out  1
- usb_utmi_rxactive  out  1
- usb_utmi_rxerror  out  1
- usb_utmi_linestate  out  2  01=J idle, 00=SE0
- usb_utmi_txready  out  1
- usb_utmi_data_out  in  DATA_W  device tx data
- usb_utmi_txvalid  in  1
- busy  out  1  any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - All UTMI outputs 0, except linestate=01.
  - pkt_in_ready=0, pkt_out_valid=0, pkt_out_last=0, busy=0.
  - FSM goes to IDLE, counters clear, skid register empties.
  - A reset mid-packet abandons the packet silently; no rxerror is produced.
- FSM states: IDLE, BUSRST, RX_SYNC, RX_DATA, TX_CAP, GAP.
- IDLE:
  - Priority is bus_reset_req > usb_utmi_txvalid > pkt_in_valid.
  - Simultaneous txvalid and pkt_in_valid: device tx wins; the host packet waits (half-duplex).
- BUSRST: linestate=00 for exactly RESET_CYCLES, then GAP.
- RX_SYNC: rxactive=1, rxvalid=0 for SYNC_CYCLES, then RX_DATA.
- RX_DATA:
  - pkt_in_ready=1.
  - On a valid&ready cycle: the next cycle drives usb_utmi_data_in=byte and rxvalid=1 for exactly one cycle.
  - If pkt_in_valid is low mid-packet: rxvalid=0 and rxactive stays high; the gap length is unbounded.
  - After the last byte has been presented: rxactive drops the following cycle, then GAP.
- TX_CAP:
  - usb_utmi_txready=1 when txvalid=1, the skid register is empty or draining this cycle, and the pacing counter is 0.
  - A byte is accepted when txvalid&txready. The pacing counter then reloads TXREADY_GAP.
  - Each accepted byte goes into a one-entry skid register. The previous skid byte is emitted with last=0.
  - When txvalid falls, the held byte is emitted with pkt_out_last=1, then GAP.
  - A txvalid drop with no bytes accepted produces no output, then GAP.
  - Downstream backpressure (pkt_out_ready=0) holds txready low. No byte is ever dropped.
- pkt_out: valid stays high until ready. Data and last are stable while valid&!ready.
- GAP: IPG_CYCLES idle, then IDLE.
- A bus_reset_req outside IDLE is latched and serviced on the next IDLE.
- Latency: pkt_in byte accepted → rxvalid 1 cycle later. Last device byte → pkt_out_valid ≤2 cycles after txvalid falls.

Optional Feature:
- Macro: USB_PHY_RXERR_INJ_EN.
- Defined:
  - Adds input port inject_err (1 bit), sampled together with a pkt_in byte.
  - When set, that byte is presented with rxerror=1 and rxvalid=0.
  - The remaining pkt_in bytes up to and including last are consumed and discarded.
  - rxactive then drops, then GAP.
- Undefined: the port is absent and rxerror is constant 0.

Decomposition:
- Shared package usb_phy_pkg:
  - FSM state enum.
  - Linestate constants LS_SE0=00, LS_J=01, LS_K=10.
  - PID constants (TOKEN_IN=69, OUT=E1, SETUP=2D, DATA0=C3, DATA1=4B, ACK=D2, NAK=5A) for benches.
- One natural sub-module: usb_phy_skid (one-entry valid/ready skid buffer with last flag), used on the TX_CAP path.

Test Plan:
- IN token: feed 69,00,10 (last on 10), SYNC_CYCLES=2 → rxactive high for 2 cycles with rxvalid low, then rxvalid on 3 consecutive cycles with data 69,00,10, rxactive low on the next cycle, busy low after 4 GAP cycles.
- Device DATA1: hold txvalid 3 cycles with C3... use 4B,AA,55 and pkt_out_ready=1 → pkt_out emits 4B,AA,55; last only on 55; txready high exactly 3 cycles.
- Backpressure: same tx with pkt_out_ready=0 for 5 cycles mid-packet → txready low while the skid is full; all 3 bytes delivered in order, none lost.
- Collision: txvalid and pkt_in_valid both rise in IDLE → device packet captured first; host packet presented only after IPG_CYCLES=4 idle cycles.
- Bus reset: pulse bus_reset_req during RX_DATA → packet completes, then linestate=00 for exactly 100 cycles, then 01.
- With USB_PHY_RXERR_INJ_EN: 8-byte DATA0 with inject_err on byte 3 → rxerror=1 for one cycle; bytes 4–8 consumed with no rxvalid; rxactive falls; the following packet is unaffected.
